ct_scheduler: RTL and testbench

Round-robin scheduler that shares one CT_module convolution engine between two requesters. It grants the engine, steers the external operand mux, and issues the start pulse. It collects the four serialized 8-bit results into a 32-bit word and returns them to the granted requester over a valid/ready handshake, with a no-progress watchdog. It sits between the two requesting front-ends and the CT_module instance.

---
 rtl/ct_scheduler.sv | 146 ++++++++++++++
 tb/tb_ct_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_scheduler.sv
// Round-robin arbiter that shares one CT_module engine between two requesters,
// packs its four serialized result bytes and returns them over valid/ready.
module ct_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        req_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        src_sel,
    output logic        en_ct,
    input  logic        ct_en_result,
    input  logic [7:0]  ct_result,
    input  logic        ct_done,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        res_valid_0,
    output logic        res_valid_1,
    input  logic        res_ready_0,
    input  logic        res_ready_1,
    output logic        busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DELIVER = 2'd3;

    // Checked one cycle early so DELIVER lands exactly TIMEOUT cycles after the last progress.
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 2);

    logic [1:0]  state;
    logic        sel;
    logic        last_gnt;
    logic [2:0]  count;
    logic        err_flag;
    logic [15:0] wdog;

    logic        pick;
    logic [2:0]  count_next;
    logic        err_next;
    logic        timeout_hit;
    logic        sel_ready;
    logic        sel_req;

    always_comb begin
        pick = req_1;
        if (req_0 && req_1) begin
            pick = ~last_gnt;
        end
        count_next = count;
        err_next   = err_flag;
        if (ct_en_result) begin
            if (count < 3'd4) begin
                count_next = count + 3'd1;
            end else begin
                err_next = 1'b1;
            end
        end
        timeout_hit = !ct_en_result && (wdog == WDOG_LIMIT);
        sel_ready   = sel ? res_ready_1 : res_ready_0;
        sel_req     = sel ? req_1 : req_0;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_gnt    <= 1'b1;
            count       <= 3'd0;
            err_flag    <= 1'b0;
            wdog        <= 16'd0;
            gnt_0       <= 1'b0;
            gnt_1       <= 1'b0;
            src_sel     <= 1'b0;
            en_ct       <= 1'b0;
            res_data    <= 32'd0;
            res_err     <= 1'b0;
            res_valid_0 <= 1'b0;
            res_valid_1 <= 1'b0;
        end else begin
            en_ct <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        sel     <= pick;
                        src_sel <= pick;
                        gnt_0   <= ~pick;
                        gnt_1   <= pick;
                        en_ct   <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    count    <= 3'd0;
                    err_flag <= 1'b0;
                    wdog     <= 16'd0;
                    res_data <= 32'd0;
                    res_err  <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (ct_en_result && (count < 3'd4)) begin
                        case (count[1:0])
                            2'd0:    res_data[31:24] <= ct_result;
                            2'd1:    res_data[23:16] <= ct_result;
                            2'd2:    res_data[15:8]  <= ct_result;
                            default: res_data[7:0]   <= ct_result;
                        endcase
                    end
                    count    <= count_next;
                    err_flag <= err_next;
                    wdog     <= ct_en_result ? 16'd0 : wdog + 16'd1;
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (ct_done) begin
                        res_err     <= err_next | (count_next != 3'd4);
                        res_valid_0 <= ~sel;
                        res_valid_1 <= sel;
                        state       <= DELIVER;
                    end else if (timeout_hit) begin
                        res_err     <= 1'b1;
                        res_valid_0 <= ~sel;
                        res_valid_1 <= sel;
                        state       <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (sel_ready || !sel_req) begin
                        res_valid_0 <= 1'b0;
                        res_valid_1 <= 1'b0;
                        gnt_0       <= 1'b0;
                        gnt_1       <= 1'b0;
                        last_gnt    <= sel;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_scheduler.sv
// Randomized bench for ct_scheduler: a job-level model predicts grants, results
// and delivery timing, and a negedge process compares every cycle.
module tb_ct_scheduler;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_0, req_1;
    logic        gnt_0, gnt_1, src_sel, en_ct;
    logic        ct_en_result;
    logic [7:0]  ct_result;
    logic        ct_done;
    logic [31:0] res_data;
    logic        res_err;
    logic        res_valid_0, res_valid_1;
    logic        res_ready_0, res_ready_1;
    logic        busy;

    ct_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .req_1(req_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .src_sel(src_sel), .en_ct(en_ct),
        .ct_en_result(ct_en_result), .ct_result(ct_result), .ct_done(ct_done),
        .res_data(res_data), .res_err(res_err),
        .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
        .res_ready_0(res_ready_0), .res_ready_1(res_ready_1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic        expGnt0, expGnt1, expSrc, expEn, expValid0, expValid1, expErr, expBusy;
    logic [31:0] expData;
    bit          checkOn = 0;
    logic        lastGnt;
    logic [7:0]  fixB[5];
    bit          useFix = 0;

    logic [31:0] seenData = 0;
    logic        seenErr = 0;
    int          enCyc = 0;
    int          deliverDelay = 0;
    logic        srcAtEn[$];
    logic        prevValid = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%h want=%h cycle=%0d", name, got, want, cyc);
        end
    endtask

    task automatic setIdle();
        expGnt0 = 0; expGnt1 = 0; expSrc = 0; expEn = 0;
        expValid0 = 0; expValid1 = 0; expErr = 0; expBusy = 0; expData = 0;
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("gnt_0", 32'(gnt_0), 32'(expGnt0));
            checkOutput("gnt_1", 32'(gnt_1), 32'(expGnt1));
            checkOutput("en_ct", 32'(en_ct), 32'(expEn));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("res_valid_0", 32'(res_valid_0), 32'(expValid0));
            checkOutput("res_valid_1", 32'(res_valid_1), 32'(expValid1));
            if (expGnt0 || expGnt1) checkOutput("src_sel", 32'(src_sel), 32'(expSrc));
            if (expValid0 || expValid1) begin
                checkOutput("res_data", res_data, expData);
                checkOutput("res_err", 32'(res_err), 32'(expErr));
            end
        end
        if (en_ct) begin
            enCyc = cyc;
            srcAtEn.push_back(src_sel);
        end
        if ((res_valid_0 || res_valid_1) && !prevValid) begin
            deliverDelay = cyc - enCyc;
            seenData = res_data;
            seenErr = res_err;
        end
        prevValid = res_valid_0 | res_valid_1;
    end

    // kind: 0 four strobes then done, 1 three strobes, 2 five strobes, 3 silent,
    // 4 two strobes then silent, 5 fourth strobe together with done.
    task automatic applyStimulus(input int kind, input bit dropIt, input int readyDelay,
                                 input bit keepAfter, input bit raiseOther, input int abortAt);
        logic       w;
        bit         stb[64];
        bit         dn[64];
        logic [7:0] byt[64];
        logic [7:0] sb[5];
        logic [7:0] got[4];
        int         nStb, pos, n, lastProg;
        bit         timedOut;
        for (int i = 0; i < 64; i++) begin
            stb[i] = 0; dn[i] = 0; byt[i] = 8'($urandom);
        end
        for (int i = 0; i < 5; i++) sb[i] = useFix ? fixB[i] : 8'($urandom);
        for (int i = 0; i < 4; i++) got[i] = 8'd0;
        nStb = (kind == 1) ? 3 : (kind == 2) ? 5 : (kind == 3) ? 0 : (kind == 4) ? 2 : 4;
        pos = $urandom_range(0, 2);
        for (int i = 0; i < nStb; i++) begin
            stb[pos] = 1;
            byt[pos] = sb[i];
            if (i < nStb - 1) pos += 1 + $urandom_range(0, 2);
        end
        if (kind == 5 || (kind == 2 && $urandom_range(0, 1) == 1)) dn[pos] = 1;
        else if (kind != 3 && kind != 4) dn[pos + 1 + $urandom_range(0, 2)] = 1;

        w = (req_0 && req_1) ? ~lastGnt : req_1;
        @(posedge clk); #1;
        expGnt0 = ~w; expGnt1 = w; expSrc = w; expEn = 1; expBusy = 1;
        if (raiseOther) begin
            if (w) req_0 = 1; else req_1 = 1;
        end
        n = 0; lastProg = 0; timedOut = 0;
        for (int t = 1; t < 64; t++) begin
            @(posedge clk); #1;
            expEn = 0;
            if (t == abortAt) begin
                reset = 1;
                ct_en_result = 0; ct_done = 0;
                req_0 = 0; req_1 = 0;
                setIdle();
                lastGnt = 1;
                @(posedge clk); #1;
                reset = 0;
                return;
            end
            ct_en_result = stb[t-1];
            ct_result = byt[t-1];
            ct_done = dn[t-1];
            if (stb[t-1]) begin
                if (n < 4) got[n] = byt[t-1];
                n++;
                lastProg = t;
            end
            if (dn[t-1]) break;
            if (t + 1 - lastProg == TO) begin
                timedOut = 1;
                break;
            end
        end
        @(posedge clk); #1;
        ct_en_result = 0; ct_done = 0;
        expValid0 = ~w; expValid1 = w;
        expData = {got[0], got[1], got[2], got[3]};
        expErr = timedOut || (n != 4);
        for (int d = 0; d <= readyDelay; d++) begin
            if (d == readyDelay) begin
                if (dropIt) begin
                    if (w) req_1 = 0; else req_0 = 0;
                end else begin
                    if (w) res_ready_1 = 1; else res_ready_0 = 1;
                end
            end
            @(posedge clk); #1;
        end
        res_ready_0 = 0; res_ready_1 = 0;
        if (w) req_1 = keepAfter; else req_0 = keepAfter;
        lastGnt = w;
        setIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        reset = 1; req_0 = 1; req_1 = 1;
        ct_en_result = 0; ct_result = 0; ct_done = 0;
        res_ready_0 = 0; res_ready_1 = 0;
        lastGnt = 1;
        setIdle();
        checkOn = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_res_data", res_data, 32'd0);
        checkOutput("rst_res_err", 32'(res_err), 32'd0);
        reset = 0;

        // Both requests held from reset: grant order 0, 1, 0.
        srcAtEn.delete();
        applyStimulus(0, 0, $urandom_range(0, 3), 1, 0, -1);
        applyStimulus(0, 0, $urandom_range(0, 3), 1, 0, -1);
        applyStimulus(0, 0, $urandom_range(0, 3), 0, 0, -1);
        req_1 = 0;
        checkOutput("order_count", srcAtEn.size(), 3);
        if (srcAtEn.size() >= 3) begin
            checkOutput("order_first", 32'(srcAtEn[0]), 32'd0);
            checkOutput("order_second", 32'(srcAtEn[1]), 32'd1);
            checkOutput("order_third", 32'(srcAtEn[2]), 32'd0);
        end

        useFix = 1;
        fixB[0] = 8'h11; fixB[1] = 8'h22; fixB[2] = 8'h33; fixB[3] = 8'h44; fixB[4] = 8'h55;
        req_0 = 1;
        applyStimulus(0, 0, 1, 0, 0, -1);
        checkOutput("lit_full_data", seenData, 32'h11223344);
        checkOutput("lit_full_err", 32'(seenErr), 32'd0);

        fixB[0] = 8'hAA; fixB[1] = 8'hBB; fixB[2] = 8'hCC;
        req_0 = 1;
        applyStimulus(1, 0, 0, 0, 0, -1);
        checkOutput("lit_short_data", seenData, 32'hAABBCC00);
        checkOutput("lit_short_err", 32'(seenErr), 32'd1);
        useFix = 0;

        req_1 = 1;
        applyStimulus(3, 0, 2, 0, 0, -1);
        checkOutput("lit_timeout_delay", deliverDelay, 32'd8);
        checkOutput("lit_timeout_data", seenData, 32'd0);
        checkOutput("lit_timeout_err", 32'(seenErr), 32'd1);

        req_0 = 1;
        applyStimulus(5, 0, 0, 0, 0, -1);
        checkOutput("lit_coincident_err", 32'(seenErr), 32'd0);
        req_0 = 1;
        applyStimulus(2, 0, 0, 0, 0, -1);
        checkOutput("lit_extra_err", 32'(seenErr), 32'd1);

        // Reset mid-WAIT, then a dropped result for requester 1 followed by requester 0.
        req_0 = 1;
        applyStimulus(0, 0, 0, 0, 0, 3);
        req_1 = 1;
        applyStimulus(0, 1, 1, 0, 1, -1);
        applyStimulus(0, 0, 0, 0, 0, -1);
        checkOutput("lit_after_drop_src", 32'(srcAtEn[srcAtEn.size()-1]), 32'd0);

        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 1) == 1) req_0 = 1;
            if ($urandom_range(0, 1) == 1) req_1 = 1;
            if (!req_0 && !req_1) req_0 = 1;
            applyStimulus($urandom_range(0, 5), $urandom_range(0, 7) == 0, $urandom_range(0, 3),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1);
        end

        req_0 = 0; req_1 = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
